// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer and its helpers.
// cnt_width sizes the stability counter so it can hold STABLE_CYCLES-1.
package debounce_pkg;

  localparam int unsigned CLK_HZ                = 50_000_000;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 500_000;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing an asynchronous level into the clk domain.
// Synchronous active-high reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/debounce_better_version.sv
// Push-button debouncer: a new synchronized level is accepted after STABLE_CYCLES
// consecutive cycles; each accepted press emits a one-cycle pb_out pulse.
//
//   db_state | meaning
//   ---------+------------------------------------------
//   0        | button released (accepted level low)
//   1        | button pressed  (accepted level high)
module debounce_better_version
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_1,
  output logic pb_out
);

  localparam int unsigned          CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             sync2;
  logic             db_state;
  logic             db_state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             pulse_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pb_1),
    .q   (sync2)
  );

  // cnt never exceeds CNT_LAST: reaching it with a differing input flips the state.
  always_comb begin
    db_state_next = db_state;
    cnt_next      = '0;
    pulse_next    = 1'b0;
    if (sync2 != db_state) begin
      if (cnt == CNT_LAST) begin
        db_state_next = sync2;
        pulse_next    = sync2;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_state <= 1'b0;
      cnt      <= '0;
      pb_out   <= 1'b0;
    end else begin
      db_state <= db_state_next;
      cnt      <= cnt_next;
      pb_out   <= pulse_next;
    end
  end

endmodule

// File: tb/tb_debounce_better_version.sv
// Bench for debounce_better_version: table vectors, directed corner sequences and
// random stimulus compared each cycle against a sliding-window reference model.
module tb_debounce_better_version;

  localparam int S = 8;

  logic clk = 1'b0;
  logic rst;
  logic pb_1;
  logic pb_out;

  always #10 clk = ~clk;

  debounce_better_version #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .pb_1   (pb_1),
    .pb_out (pb_out)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: input reaches the logic two edges late; the accepted level
  // flips once the last S delivered samples all disagree with it.
  bit m_p1, m_p2, m_db, m_exp, m_valid, qualify;
  bit hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_p1 = 0; m_p2 = 0; m_db = 0; m_exp = 0; m_valid = 1;
      hist.delete();
    end else begin
      hist.push_back(m_p2);
      if (hist.size() > S) void'(hist.pop_front());
      qualify = (hist.size() == S);
      foreach (hist[i]) if (hist[i] == m_db) qualify = 0;
      m_exp = qualify && !m_db;
      if (qualify) begin
        m_db = !m_db;
        hist.delete();
      end
      m_p2 = m_p1;
      m_p1 = pb_1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if (pb_out !== m_exp) begin
        fails++;
        $display("FAIL model_cmp t=%0t pb_out=%b expected=%b", $time, pb_out, m_exp);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Drive inputs at a falling edge; return at the falling edge after the next rising edge.
  task automatic cyc(input bit r, input bit p);
    rst  = r;
    pb_1 = p;
    @(negedge clk);
  endtask

  // j = 0 is the first edge sampling level p.
  task automatic run_level(input bit p, input int n, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int j = 0; j < n; j++) begin
      cyc(1'b0, p);
      if (pb_out === 1'b1) begin
        if (first < 0) first = j;
        cnt++;
      end
    end
  endtask

  typedef struct {
    bit r;
    bit p;
    bit exp;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int first, cnt, total, tmp;
    bit lvl;
    int len;

    for (int i = 0; i < 23; i++) begin
      tbl[i].r   = (i < 3);
      tbl[i].p   = 1'b1;
      tbl[i].exp = (i == 12);
    end

    rst  = 1'b1;
    pb_1 = 1'b0;
    @(negedge clk);

    // Reset held with button pressed, then a clean 20-cycle press.
    total = 0;
    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].r, tbl[i].p);
      check($sformatf("table[%0d]", i), pb_out, tbl[i].exp);
      if (pb_out === 1'b1) total++;
    end
    check("table_pulse_count", total, 1);

    run_level(1'b0, 12, first, cnt);
    check("release_no_pulse", cnt, 0);

    // Bounce train 1,0,1,1,0 then steady 1 starting at the final 1.
    total = 0;
    cyc(1'b0, 1'b1); total += pb_out;
    cyc(1'b0, 1'b0); total += pb_out;
    cyc(1'b0, 1'b1); total += pb_out;
    cyc(1'b0, 1'b1); total += pb_out;
    cyc(1'b0, 1'b0); total += pb_out;
    check("bounce_no_pulse", total, 0);
    run_level(1'b1, 14, first, cnt);
    check("bounce_pulse_pos", first, 9);
    check("bounce_pulse_count", cnt, 1);

    // Short glitch low while pressed: no second pulse.
    run_level(1'b0, 3, first, cnt);
    tmp = cnt;
    run_level(1'b1, 15, first, cnt);
    check("glitch_no_pulse", tmp + cnt, 0);

    // Release, press, release, press: two pulses.
    total = 0;
    run_level(1'b0, 12, first, cnt); total += cnt;
    run_level(1'b1, 12, first, cnt); total += cnt;
    check("press2_pos", first, 9);
    run_level(1'b0, 12, first, cnt); total += cnt;
    run_level(1'b1, 12, first, cnt); total += cnt;
    check("two_presses_pulses", total, 2);

    // Exactly S-1 samples high is rejected; exactly S samples high is accepted.
    run_level(1'b0, 12, first, cnt);
    run_level(1'b1, S - 1, first, cnt); tmp = cnt;
    run_level(1'b0, 12, first, cnt);
    check("short_press_rejected", tmp + cnt, 0);
    run_level(1'b1, S, first, cnt); tmp = cnt;
    run_level(1'b0, 3, first, cnt);
    check("exact_press_accepted", tmp + cnt, 1);
    run_level(1'b0, 12, first, cnt);

    // Reset in the middle of a count discards it; qualification restarts.
    run_level(1'b1, 5, first, cnt);
    cyc(1'b1, 1'b1);
    check("reset_mid_out", pb_out, 0);
    run_level(1'b1, 14, first, cnt);
    check("reset_mid_pos", first, 9);
    check("reset_mid_count", cnt, 1);

    // Long hold produces a single pulse.
    run_level(1'b1, 60, first, cnt);
    check("hold_no_repeat", cnt, 0);

    // Random runs with occasional reset, checked by the model every cycle.
    for (int k = 0; k < 500; k++) begin
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      if ($urandom_range(0, 40) == 0) cyc(1'b1, lvl);
      run_level(lvl, len, first, cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/debounce_better_version.md
DEBOUNCE_BETTER_VERSION -- requirements
Module: debounce_better_version

Interface
REQ-001 Parameter STABLE_CYCLES, default 500000, is the number of consecutive clk cycles the synchronized input must hold a new level before it is accepted (10 ms at 50 MHz); legal range 2..2^24.
REQ-002 clk  input  1  system clock, nominal 50 MHz (20 ns period); all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pb_1  input  1  raw, asynchronous, bouncing push-button level; 1 = pressed.
REQ-005 pb_out  output  1  registered single-clk-cycle pulse, one per accepted press.
REQ-006 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high on rst.

Function
REQ-007 pb_1 SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-008 The block SHALL hold a debounced state bit db_state and a counter cnt of width $clog2(STABLE_CYCLES).
REQ-009 When sync2 == db_state, cnt SHALL clear to 0 on the next edge.
REQ-010 When sync2 != db_state and cnt < STABLE_CYCLES-1, cnt SHALL increment by 1.
REQ-011 When sync2 != db_state and cnt == STABLE_CYCLES-1, db_state SHALL take sync2 and cnt SHALL clear to 0 on the same edge.
REQ-012 Any single-cycle return of sync2 to db_state SHALL restart the count; cnt SHALL never wrap.
REQ-013 pb_out SHALL be 1 for exactly the one cycle following the edge on which db_state changes 0->1, and 0 otherwise.
REQ-014 A 1->0 transition of db_state SHALL NOT produce a pulse.
REQ-015 Latency: if edge E0 is the first edge sampling pb_1 = 1 and pb_1 stays 1, db_state and pb_out SHALL rise at edge E0+STABLE_CYCLES+1, and pb_out SHALL fall at edge E0+STABLE_CYCLES+2.
REQ-016 A release SHALL become effective only after the same STABLE_CYCLES stability; a new pulse SHALL require an accepted release first.
REQ-017 Holding the button indefinitely SHALL produce exactly one pulse.

Reset
REQ-018 While rst = 1 at an edge, sync1, sync2, db_state, cnt and pb_out SHALL all become 0.
REQ-019 Reset asserted mid-count SHALL discard the count.
REQ-020 After reset deassertion with pb_1 already 1, a pulse SHALL occur after full qualification (per REQ-015, counted from the first post-reset edge).
REQ-021 rst SHALL take priority over all other updates.

Structure
REQ-022 A shared package debounce_pkg SHALL hold the constants CLK_HZ = 50000000 and DEFAULT_STABLE_CYCLES = 500000.
REQ-023 The synchronizer SHALL be a sub-module sync_2ff (clk, rst, d, q; reset value 0).
REQ-024 The counter/state logic and the pulse generator SHALL reside in debounce_better_version.

Verification
REQ-025 Benches SHALL run at clk = 20 ns and use STABLE_CYCLES = 8 unless stated otherwise.
REQ-026 Scenario 1: rst high for 3 cycles with pb_1 = 1 -> pb_out = 0 throughout; after release, pulse at E0+9.
REQ-027 Scenario 2: clean press held 20 cycles from E0 -> pb_out = 1 only in the cycle after edge E0+9; exactly one pulse.
REQ-028 Scenario 3: bounce train 1,0,1,1,0,1 (one cycle each) then steady 1 -> no pulse during bounce; one pulse 9 edges after the last 0->1 sample.
REQ-029 Scenario 4: press accepted, glitch to 0 for 3 cycles, back to 1 -> no second pulse; db_state stays 1.
REQ-030 Scenario 5: press, release held 10+ cycles, press again -> two pulses total.
REQ-031 Scenario 6: default STABLE_CYCLES. Apply 0 for 10 ms, 1 for 20 ms, 0 for 10 ms, 1 for 30 ms, then sub-microsecond glitches (100/40/10/30/10 ns, 1000 ns high) -> exactly 2 pulses, one ~10 ms after each long press; none from the glitches.
